// File: rtl/fifo_main_to_cache_sync_pkg.sv
// rtl/fifo_main_to_cache_sync_pkg.sv - shared cache refill defaults and FIFO helper types
package fifo_main_to_cache_sync_pkg;

  localparam int unsigned CACHE_LINE_W  = 512;
  localparam int unsigned REFILL_DEPTH  = 64;
  localparam int unsigned REFILL_AFULL  = 56;
  localparam int unsigned REFILL_AEMPTY = 8;

  typedef enum logic [1:0] {
    CNT_HOLD = 2'd0,
    CNT_INC  = 2'd1,
    CNT_DEC  = 2'd2
  } cnt_op_e;

  // A depth of 1 still needs a one-bit pointer.
  function automatic int unsigned ptr_width(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/fifo_main_to_cache_sync_if.sv
// rtl/fifo_main_to_cache_sync_if.sv - refill FIFO handshake, data and status bundle
interface fifo_main_to_cache_sync_if
  import fifo_main_to_cache_sync_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = CACHE_LINE_W,
  parameter int unsigned CNT_W      = $clog2(REFILL_DEPTH + 1)
);

  logic                  flush;
  logic                  wr_valid;
  logic                  wr_ready;
  logic [DATA_WIDTH-1:0] write_data;
  logic                  rd_valid;
  logic                  rd_ready;
  logic [DATA_WIDTH-1:0] read_data;
  logic                  full;
  logic                  empty;
  logic                  almost_full;
  logic                  almost_empty;
  logic [CNT_W-1:0]      count;
  logic                  overflow;
  logic                  underflow;

  modport master (
    output flush, wr_valid, write_data, rd_ready,
    input  wr_ready, rd_valid, read_data, full, empty,
    input  almost_full, almost_empty, count, overflow, underflow
  );

  modport slave (
    input  flush, wr_valid, write_data, rd_ready,
    output wr_ready, rd_valid, read_data, full, empty,
    output almost_full, almost_empty, count, overflow, underflow
  );

endinterface

// File: rtl/fifo_main_to_cache_sync_ram.sv
// rtl/fifo_main_to_cache_sync_ram.sv - DEPTH x DATA_WIDTH array, sync write, async read
module fifo_sync_ram #(
  parameter int unsigned DATA_WIDTH = 512,
  parameter int unsigned DEPTH      = 64,
  parameter int unsigned PTR_W      = 6
) (
  input  logic                  clk,
  input  logic                  i_wr_en,
  input  logic [PTR_W-1:0]      i_wr_addr,
  input  logic [DATA_WIDTH-1:0] i_wr_data,
  input  logic [PTR_W-1:0]      i_rd_addr,
  output logic [DATA_WIDTH-1:0] o_rd_data
);

  // Contents are deliberately left unreset so a vendor macro can drop in.
  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end

  assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/fifo_main_to_cache_sync.sv
// rtl/fifo_main_to_cache_sync.sv - FWFT main-memory-to-cache refill FIFO with watermarks and error flags
module fifo_main_to_cache_sync
  import fifo_main_to_cache_sync_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = CACHE_LINE_W,
  parameter int unsigned DEPTH        = REFILL_DEPTH,
  parameter int unsigned AFULL_LEVEL  = REFILL_AFULL,
  parameter int unsigned AEMPTY_LEVEL = REFILL_AEMPTY,
  parameter int unsigned CNT_W        = $clog2(DEPTH + 1),
  parameter int unsigned PTR_W        = ptr_width(DEPTH)
) (
  input logic                      clk,
  input logic                      rst_n,
  fifo_main_to_cache_sync_if.slave bus
);

  localparam logic [CNT_W-1:0] L_DEPTH  = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] L_AFULL  = CNT_W'(AFULL_LEVEL);
  localparam logic [CNT_W-1:0] L_AEMPTY = CNT_W'(AEMPTY_LEVEL);
  localparam logic [PTR_W-1:0] L_LAST   = PTR_W'(DEPTH - 1);

  // Explicit wrap so non-power-of-two depths work.
  function automatic logic [PTR_W-1:0] f_ptr_next(input logic [PTR_W-1:0] ptr);
    return (ptr == L_LAST) ? '0 : ptr + PTR_W'(1);
  endfunction

  logic [PTR_W-1:0]      r_wr_ptr;
  logic [PTR_W-1:0]      r_rd_ptr;
  logic [CNT_W-1:0]      r_count;
  logic                  r_overflow;
  logic                  r_underflow;

  logic                  w_full;
  logic                  w_empty;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_ram_wr_en;
  logic [DATA_WIDTH-1:0] w_ram_rd_data;
  cnt_op_e               w_cnt_op;

  assign w_full      = (r_count == L_DEPTH);
  assign w_empty     = (r_count == '0);
  assign w_push      = bus.wr_valid && !w_full;
  assign w_pop       = bus.rd_ready && !w_empty;
  assign w_ram_wr_en = w_push && !bus.flush;

  always_comb begin
    w_cnt_op = CNT_HOLD;
    if (w_push && !w_pop) begin
      w_cnt_op = CNT_INC;
    end else if (w_pop && !w_push) begin
      w_cnt_op = CNT_DEC;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      // Error flags record the attempt even when a flush discards the traffic.
      if (bus.wr_valid && w_full) begin
        r_overflow <= 1'b1;
      end
      if (bus.rd_ready && w_empty) begin
        r_underflow <= 1'b1;
      end
      if (bus.flush) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
        r_count  <= '0;
      end else begin
        if (w_push) begin
          r_wr_ptr <= f_ptr_next(r_wr_ptr);
        end
        if (w_pop) begin
          r_rd_ptr <= f_ptr_next(r_rd_ptr);
        end
        unique case (w_cnt_op)
          CNT_INC: r_count <= r_count + CNT_W'(1);
          CNT_DEC: r_count <= r_count - CNT_W'(1);
          default: r_count <= r_count;
        endcase
      end
    end
  end

  fifo_sync_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .PTR_W      (PTR_W)
  ) u_ram (
    .clk       (clk),
    .i_wr_en   (w_ram_wr_en),
    .i_wr_addr (r_wr_ptr),
    .i_wr_data (bus.write_data),
    .i_rd_addr (r_rd_ptr),
    .o_rd_data (w_ram_rd_data)
  );

  assign bus.read_data    = w_empty ? '0 : w_ram_rd_data;
  assign bus.wr_ready     = !w_full;
  assign bus.rd_valid     = !w_empty;
  assign bus.full         = w_full;
  assign bus.empty        = w_empty;
  assign bus.almost_full  = (r_count >= L_AFULL);
  assign bus.almost_empty = (r_count <= L_AEMPTY);
  assign bus.count        = r_count;
  assign bus.overflow     = r_overflow;
  assign bus.underflow    = r_underflow;

endmodule

// File: tb/tb_fifo_main_to_cache_sync.sv
// tb/tb_fifo_main_to_cache_sync.sv - scoreboard bench for the refill FIFO at depths 64 and 5
module tb_fifo_main_to_cache_sync;
  import fifo_main_to_cache_sync_pkg::*;

  localparam int DW   = 512;
  localparam int CW64 = $clog2(64 + 1);
  localparam int CW5  = $clog2(5 + 1);

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  fifo_main_to_cache_sync_if #(.DATA_WIDTH(DW), .CNT_W(CW64)) if64 ();
  fifo_main_to_cache_sync_if #(.DATA_WIDTH(DW), .CNT_W(CW5))  if5 ();

  fifo_main_to_cache_sync #(
    .DATA_WIDTH(DW), .DEPTH(64), .AFULL_LEVEL(56), .AEMPTY_LEVEL(8), .CNT_W(CW64)
  ) dut64 (.clk(clk), .rst_n(rst_n), .bus(if64));

  fifo_main_to_cache_sync #(
    .DATA_WIDTH(DW), .DEPTH(5), .AFULL_LEVEL(4), .AEMPTY_LEVEL(1), .CNT_W(CW5)
  ) dut5 (.clk(clk), .rst_n(rst_n), .bus(if5));

  bit            sel5;
  int            m_depth, m_afull, m_aempty;
  bit            m_ovf, m_unf;
  logic [DW-1:0] sb[$];
  int            n_cmp = 0;
  int            n_err = 0;

  task automatic check_eq(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input bit wv, input logic [DW-1:0] wd, input bit rr, input bit fl);
    if (sel5) begin
      if5.wr_valid = wv; if5.write_data = wd; if5.rd_ready = rr; if5.flush = fl;
    end else begin
      if64.wr_valid = wv; if64.write_data = wd; if64.rd_ready = rr; if64.flush = fl;
    end
  endtask

  function automatic logic [DW-1:0] obs_rdata();
    return sel5 ? if5.read_data : if64.read_data;
  endfunction

  function automatic int obs_count();
    return sel5 ? int'(if5.count) : int'(if64.count);
  endfunction

  function automatic logic [7:0] obs_flags();
    if (sel5)
      return {if5.full, if5.empty, if5.almost_full, if5.almost_empty,
              if5.wr_ready, if5.rd_valid, if5.overflow, if5.underflow};
    return {if64.full, if64.empty, if64.almost_full, if64.almost_empty,
            if64.wr_ready, if64.rd_valid, if64.overflow, if64.underflow};
  endfunction

  function automatic logic [7:0] model_flags();
    int s = sb.size();
    return {s == m_depth, s == 0, s >= m_afull, s <= m_aempty,
            s != m_depth, s != 0, m_ovf, m_unf};
  endfunction

  task automatic check_state(input string tag);
    check_eq({tag, "_count"}, DW'(obs_count()), DW'(sb.size()));
    check_eq({tag, "_flags"}, DW'(obs_flags()), DW'(model_flags()));
    if (sb.size() == 0) check_eq({tag, "_rdata_zero"}, obs_rdata(), '0);
    else                check_eq({tag, "_head"}, obs_rdata(), sb[0]);
  endtask

  task automatic use_dut(input bit five);
    sel5 = five;
    if (five) begin m_depth = 5;  m_afull = 4;  m_aempty = 1; end
    else      begin m_depth = 64; m_afull = 56; m_aempty = 8; end
  endtask

  task automatic rst_pulse(input int n);
    rst_n = 1'b0;
    drive(1'b0, '0, 1'b0, 1'b0);
    sb.delete();
    m_ovf = 1'b0;
    m_unf = 1'b0;
    repeat (n) @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    check_state("rst");
  endtask

  // One clock of stimulus: the head is scored before the edge that pops it.
  task automatic cycle(input bit wv, input logic [DW-1:0] wd, input bit rr, input bit fl);
    int s;
    bit push_ok, pop_ok;
    drive(wv, wd, rr, fl);
    #1;
    s = sb.size();
    if (rr && s > 0) check_eq("pop_data", obs_rdata(), sb[0]);
    if (wv && s == m_depth) m_ovf = 1'b1;
    if (rr && s == 0) m_unf = 1'b1;
    if (fl) begin
      sb.delete();
    end else begin
      push_ok = wv && (s < m_depth);
      pop_ok  = rr && (s > 0);
      if (pop_ok) void'(sb.pop_front());
      if (push_ok) sb.push_back(wd);
    end
    @(posedge clk);
    #1;
    drive(1'b0, '0, 1'b0, 1'b0);
    #1;
    check_state("cyc");
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] f;
    int dv;
    if64.wr_valid = 0; if64.write_data = '0; if64.rd_ready = 0; if64.flush = 0;
    if5.wr_valid = 0;  if5.write_data = '0;  if5.rd_ready = 0;  if5.flush = 0;
    rst_n = 1'b0;
    @(posedge clk);
    #1;

    use_dut(1'b0);
    rst_pulse(2);
    f = obs_flags();
    check_eq("reset_flags", DW'(f), DW'(8'b0101_1000));
    check_eq("reset_rdata", obs_rdata(), '0);

    for (int i = 0; i < 64; i++) begin
      cycle(1'b1, DW'(i), 1'b0, 1'b0);
      f = obs_flags();
      check_eq("afull_level", DW'(f[5]), DW'(i + 1 >= 56));
    end
    f = obs_flags();
    check_eq("full_at_64", DW'({f[7], f[3]}), DW'(2'b10));
    check_eq("count_64", DW'(obs_count()), DW'(64));

    for (int i = 0; i < 64; i++) begin
      check_eq("drain_order", obs_rdata(), DW'(i));
      cycle(1'b0, '0, 1'b1, 1'b0);
    end
    f = obs_flags();
    check_eq("empty_after_drain", DW'(f[6]), DW'(1));

    for (int i = 0; i < 4; i++) cycle(1'b1, DW'(100 + i), 1'b0, 1'b0);
    cycle(1'b1, DW'(104), 1'b1, 1'b0);
    check_eq("pushpop_count", DW'(obs_count()), DW'(4));
    check_eq("pushpop_head", obs_rdata(), DW'(101));
    for (int i = 0; i < 4; i++) cycle(1'b0, '0, 1'b1, 1'b0);

    for (int i = 0; i < 64; i++) cycle(1'b1, DW'(32'hC000 + i), 1'b0, 1'b0);
    cycle(1'b1, DW'(32'hDEAD), 1'b1, 1'b0);
    check_eq("full_pushpop_count", DW'(obs_count()), DW'(63));
    f = obs_flags();
    check_eq("overflow_set", DW'(f[1]), DW'(1));
    for (int i = 0; i < 63; i++) cycle(1'b0, '0, 1'b1, 1'b0);

    cycle(1'b1, DW'(32'h77), 1'b1, 1'b0);
    check_eq("empty_pushpop_count", DW'(obs_count()), DW'(1));
    check_eq("empty_pushpop_data", obs_rdata(), DW'(32'h77));
    f = obs_flags();
    check_eq("underflow_set", DW'(f[0]), DW'(1));

    for (int i = 0; i < 9; i++) cycle(1'b1, DW'(200 + i), 1'b0, 1'b0);
    check_eq("pre_flush_count", DW'(obs_count()), DW'(10));
    cycle(1'b1, DW'(32'h5555), 1'b1, 1'b1);
    f = obs_flags();
    check_eq("flush_state", DW'({f[6], f[1], f[0]}), DW'(3'b111));
    check_eq("flush_rdata", obs_rdata(), '0);

    for (int i = 0; i < 20; i++) cycle(1'b1, {$urandom(), $urandom(), 448'(i)}, 1'b0, 1'b0);
    rst_pulse(1);
    f = obs_flags();
    check_eq("midrst_flags", DW'(f), DW'(8'b0101_1000));
    cycle(1'b1, DW'(32'hA5), 1'b0, 1'b0);
    check_eq("post_rst_data", obs_rdata(), DW'(32'hA5));
    f = obs_flags();
    check_eq("post_rst_valid", DW'(f[2]), DW'(1));

    use_dut(1'b1);
    rst_pulse(1);
    dv = 0;
    for (int r = 0; r < 10; r++) begin
      for (int k = 0; k < 3; k++) begin
        cycle(1'b1, DW'(dv), 1'b0, 1'b0);
        dv++;
        check_eq("wrap_count_le3", DW'(obs_count() <= 3), DW'(1));
      end
      for (int k = 0; k < 3; k++) begin
        check_eq("wrap_order", obs_rdata(), DW'(dv - 3 + k));
        cycle(1'b0, '0, 1'b1, 1'b0);
      end
    end
    for (int i = 0; i < 5; i++) cycle(1'b1, DW'(300 + i), 1'b0, 1'b0);
    f = obs_flags();
    check_eq("d5_full", DW'(f[7]), DW'(1));
    for (int i = 0; i < 5; i++) cycle(1'b0, '0, 1'b1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
